rot_issue_seq: RTL
==================

Name: rot_issue_seq

Overview:
Upstream sequencer and register file that feeds the 8-bit rotate stage and consumes its result. It accepts one 8-bit instruction at a time and holds eight 8-bit general registers. For rotate ops it drives operand, direction and start-select to the rotate stage, then waits out that stage's busy pulse and writes the result back. It also executes register load and register read-out ops locally.

Parameters:
TMO, 15, max cycles spent in either wait state before abort (counter width 4 bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
instr  input  8  instruction: [7:5] opcode, [4:2] register index, [1:0] ignored
data_in  input  8  immediate operand for LDI, sampled with instr
instr_valid  input  1  instr/data_in valid
instr_ready  output  1  block can accept an instruction
rot_in  output  8  operand to rotate stage
rot_cntrl  output  3  direction to rotate stage: 3'b000 left, 3'b001 right
rot_sel  output  4  rotate stage select: 4'b0000 = start, 4'b1111 = idle
rot_busy  input  1  rotate stage busy/ctr flag
rot_out  input  8  rotate stage result
dout  output  8  result/read-out data
dout_valid  output  1  one-cycle strobe qualifying dout
err  output  1  one-cycle strobe: illegal opcode or rotate timeout

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, regs r0..r7=0, instr_ready=1, rot_in=0, rot_cntrl=3'b000, rot_sel=4'b1111, dout=0, dout_valid=0, err=0, timeout counter=0.
- Reset overrides everything, including mid-operation. No writeback occurs. rot_sel returns to 4'b1111 on the same edge.
- Accept = instr_valid & instr_ready at a rising edge. instr_ready=1 only in IDLE.
- Opcodes:
  - 000 ROL: rotate reg left, write back.
  - 001 ROR: rotate reg right, write back.
  - 010 LDI: reg <= data_in.
  - 011 MOV: dout <= reg.
  - 100-111: illegal.
- LDI: completes on the accept edge. Reg is updated, state stays IDLE, no dout_valid.
- MOV: completes on the accept edge. dout=reg and dout_valid=1 for the following cycle; state stays IDLE.
- Illegal: err=1 for one cycle, no state change, regs unchanged.
- ROL/ROR state sequence:
  - IDLE -> ISSUE on accept. Latch reg index; rot_in=reg value, rot_cntrl=000/001.
  - ISSUE (exactly one cycle): rot_sel=4'b0000. Next state WAIT_HI, rot_sel back to 4'b1111.
  - WAIT_HI: when rot_busy=1, capture rot_out and go to WAIT_LO. Otherwise increment the counter.
  - WAIT_LO: when rot_busy=0, go to WB. Otherwise increment the counter.
  - WB (one cycle): reg[idx] <= captured result, dout=result, dout_valid=1 next cycle. Then IDLE.
- Counter clears on entering WAIT_HI and on WAIT_HI->WAIT_LO.
- Timeout: if the counter reaches TMO in WAIT_HI or WAIT_LO, raise err=1 for one cycle, return to IDLE, no writeback, register unchanged.
- Latency: with a rotate stage holding busy for 3 cycles, instr_ready returns 6 cycles after accept (ISSUE 1, WAIT_HI 1, WAIT_LO 3, WB 1).
- rot_in and rot_cntrl hold stable from ISSUE until IDLE.
- dout holds its last value between strobes.
- A WB result targeting the same reg as the next instruction is visible to that instruction, because the next accept is no earlier than the cycle after WB.
- Rotation arithmetic is owned by the rotate stage; this block only transports 8-bit values, with no width extension.

Test Plan:
- instr=0x48 (LDI r2), data_in=0x81; then 0x08 (ROL r2); then 0x68 (MOV r2) -> rot_in=0x81, rot_cntrl=000, rot_sel=0000 for exactly 1 cycle. After WB, dout=0x03 with dout_valid. MOV strobes dout=0x03.
- LDI r5=0x01; then instr=0x34 (ROR r5); then MOV r5 -> rot_cntrl=001, writeback 0x80, dout=0x80. instr_ready low for 6 cycles with a 3-cycle rotate model.
- ROL issued with rot_busy tied 0 -> err pulse 15 cycles after entering WAIT_HI. Reg unchanged (MOV returns old value). instr_ready=1 next cycle.
- instr=0xE0 (illegal) -> err=1 for one cycle, instr_ready stays 1, no dout_valid, all regs unchanged.
- rst_n=0 during WAIT_LO -> next cycle state IDLE, rot_sel=1111, instr_ready=1, err=0. MOV r2 returns 0x00.
- instr_valid held high with back-to-back LDI r0..r7 (values 0x10..0x17), then MOVs -> one accept per cycle, reads return 0x10..0x17 in order.

Source files
------------

// File: rtl/rot_issue_seq.sv
// rot_issue_seq: instruction sequencer and 8x8 register file driving an external rotate stage
module rot_issue_seq #(
  parameter logic [3:0] TMO = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic [7:0] data_in,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [7:0] rot_in,
  output logic [2:0] rot_cntrl,
  output logic [3:0] rot_sel,
  input  logic       rot_busy,
  input  logic [7:0] rot_out,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, WB} state_t;
  state_t state, nxt;
  logic [7:0] regs [8];
  logic [2:0] idx;
  logic [7:0] res;
  logic [3:0] cnt;
  logic [2:0] op, ri;
  logic acc, tmo_hit, unused_ok;
  assign op = instr[7:5];
  assign ri = instr[4:2];
  assign unused_ok = ^instr[1:0];
  assign instr_ready = state == IDLE;
  assign rot_sel = state == ISSUE ? 4'b0000 : 4'b1111;
  assign acc = instr_valid & instr_ready;
  assign tmo_hit = cnt == TMO - 4'd1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc && op[2:1] == 2'b00 ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT_HI;
      WAIT_HI: nxt = rot_busy ? WAIT_LO : tmo_hit ? IDLE : WAIT_HI;
      WAIT_LO: nxt = !rot_busy ? WB : tmo_hit ? IDLE : WAIT_LO;
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      idx <= '0;
      res <= '0;
      cnt <= '0;
      rot_in <= '0;
      rot_cntrl <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (op[2]) err <= 1'b1;
          else if (op == 3'b010) regs[ri] <= data_in;
          else if (op == 3'b011) begin
            dout <= regs[ri];
            dout_valid <= 1'b1;
          end else begin
            idx <= ri;
            rot_in <= regs[ri];
            rot_cntrl <= {2'b00, op[0]};
          end
        end
        ISSUE: cnt <= '0;
        WAIT_HI: if (rot_busy) begin
          res <= rot_out;
          cnt <= '0;
        end else if (tmo_hit) err <= 1'b1;
        else cnt <= cnt + 4'd1;
        WAIT_LO: if (rot_busy) begin
          if (tmo_hit) err <= 1'b1;
          else cnt <= cnt + 4'd1;
        end
        WB: begin
          regs[idx] <= res;
          dout <= res;
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
